dvp_tx: RTL

Parallel DVP (OV5640-style) transmitter that turns an internal RGB565 pixel stream into `cmos_vsync` / `cmos_href` / `cmos_pclk` / 8-bit data. It is the counterpart of the camera-capture front end in the video-input path. It serves as an on-board camera emulator, so the capture, processing, DMA and HDMI chain can be exercised without a sensor and DVP links can be looped back between boards. The block frames pixels into lines and frames with programmable blanking and sends each pixel as two bytes, MSB byte first.

---
 rtl/dvp_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dvp_tx.sv
// DVP (OV5640-style) camera emulator: frames an RGB565 pixel stream into
// vsync/href/pclk and 8-bit data, two bytes per pixel, high byte first.
module dvp_tx #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int H_BLANK     = 256,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        underrun
);

  localparam logic [12:0] LINE_LAST   = 13'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [12:0] HREF_SLOTS  = 13'(2 * H_ACTIVE);
  localparam logic [11:0] VSYNC_LAST  = 12'(VSYNC_LINES - 1);
  localparam logic [11:0] VBACK_LAST  = 12'(V_BACK - 1);
  localparam logic [11:0] ACTIVE_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VFRONT_LAST = 12'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_phase;
  logic [12:0] r_h_cnt, w_h_nxt;
  logic [11:0] r_v_cnt, w_v_nxt, w_v_last;
  logic        r_vsync, r_href;
  logic [7:0]  r_data, r_lo_byte, w_data_nxt;
  logic [15:0] r_buf;
  logic        r_buf_full, r_underrun;
  logic        w_slot_start, w_href_nxt, w_hi_slot, w_enter_vsync, w_accept;

  // The edge on which phase falls 1->0 opens a new byte slot.
  assign w_slot_start = r_phase;
  assign s_ready      = (r_state != S_IDLE) && !r_buf_full;
  assign w_accept     = s_valid && s_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    case (r_state)
      S_VBACK:  w_v_last = VBACK_LAST;
      S_ACTIVE: w_v_last = ACTIVE_LAST;
      S_VFRONT: w_v_last = VFRONT_LAST;
      default:  w_v_last = VSYNC_LAST;
    endcase
    if (r_state == S_IDLE) begin
      if (enable) begin
        w_state_nxt = S_VSYNC;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
      end
    end else if (r_h_cnt != LINE_LAST) begin
      w_h_nxt = r_h_cnt + 13'd1;
    end else begin
      w_h_nxt = '0;
      if (r_v_cnt != w_v_last) begin
        w_v_nxt = r_v_cnt + 12'd1;
      end else begin
        w_v_nxt = '0;
        case (r_state)
          S_VSYNC:  w_state_nxt = S_VBACK;
          S_VBACK:  w_state_nxt = S_ACTIVE;
          S_ACTIVE: w_state_nxt = S_VFRONT;
          S_VFRONT: w_state_nxt = enable ? S_VSYNC : S_IDLE;
          default:  w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Outputs are computed for the slot about to start, then registered.
  assign w_href_nxt    = (w_state_nxt == S_ACTIVE) && (w_h_nxt < HREF_SLOTS);
  assign w_hi_slot     = w_href_nxt && !w_h_nxt[0];
  assign w_enter_vsync = (w_state_nxt == S_VSYNC) && (r_state != S_VSYNC);

  always_comb begin
    w_data_nxt = 8'h00;
    if (w_hi_slot) begin
      w_data_nxt = r_buf_full ? r_buf[15:8] : 8'h00;
    end else if (w_href_nxt) begin
      w_data_nxt = r_lo_byte;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 1'b0;
      r_state    <= S_IDLE;
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_vsync    <= 1'b0;
      r_href     <= 1'b0;
      r_data     <= 8'h00;
      r_lo_byte  <= 8'h00;
      r_buf_full <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_phase <= !r_phase;
      // Accept needs an empty buffer and drain needs a full one, so a pixel
      // drained on this edge cannot be replaced before the next edge.
      if (w_accept) begin
        r_buf_full <= 1'b1;
      end else if (w_slot_start && w_hi_slot) begin
        r_buf_full <= 1'b0;
      end
      if (w_slot_start) begin
        r_state <= w_state_nxt;
        r_h_cnt <= w_h_nxt;
        r_v_cnt <= w_v_nxt;
        r_vsync <= (w_state_nxt == S_VSYNC);
        r_href  <= w_href_nxt;
        r_data  <= w_data_nxt;
        if (w_hi_slot) begin
          r_lo_byte <= r_buf_full ? r_buf[7:0] : 8'h00;
        end
        if (w_enter_vsync) begin
          r_underrun <= 1'b0;
        end else if (w_hi_slot && !r_buf_full) begin
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // NOTE: the pixel store has no reset; r_buf_full gates every read of it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf <= s_data;
    end
  end

  assign dvp_pclk  = r_phase;
  assign dvp_vsync = r_vsync;
  assign dvp_href  = r_href;
  assign dvp_data  = r_data;
  assign underrun  = r_underrun;

endmodule
